// File: rtl/digit_bbox_detect.sv
// Per-frame bounding box of black pixels plus a white-to-black transition count, reported at each vsync rise.
// Optional BBOX_NOISE_FILTER_EN: a black pixel qualifies only when the previous pixel of its line was also black.
module digit_bbox_detect #(
    parameter int X_W   = 11,
    parameter int Y_W   = 10,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_vsync,
    input  logic             frame_hsync,
    input  logic             frame_de,
    input  logic             monoc,
    input  logic             monoc_fall,
    output logic [X_W-1:0]   x_min,
    output logic [X_W-1:0]   x_max,
    output logic [Y_W-1:0]   y_min,
    output logic [Y_W-1:0]   y_max,
    output logic [CNT_W-1:0] trans_cnt,
    output logic             bbox_found,
    output logic             bbox_valid,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        SCAN      = 2'd1,
        REPORT    = 2'd2
    } state_t;

    state_t state_q;

    logic             vs_q, de_q;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [X_W-1:0]   min_x_q, min_x_d, max_x_q, max_x_d;
    logic [Y_W-1:0]   min_y_q, min_y_d, max_y_q, max_y_d;
    logic [CNT_W-1:0] trans_q, trans_d;
    logic             hit_q, hit_d;

    logic [X_W-1:0]   x_min_q, x_max_q;
    logic [Y_W-1:0]   y_min_q, y_max_q;
    logic [CNT_W-1:0] trans_cnt_q;
    logic             found_q, valid_q;

    logic             rise, accum_en, blk, qual;
    logic [X_W-1:0]   lo_x;

    logic unused_hsync;
    assign unused_hsync = frame_hsync;

    assign rise     = frame_vsync & ~vs_q;
    // The vsync-rise cycle itself belongs to neither frame.
    assign accum_en = (state_q != WAIT_SYNC) && !rise;
    assign blk      = frame_de & ~monoc;

`ifdef BBOX_NOISE_FILTER_EN
    logic prev_blk_q, prev_blk_d;
    assign prev_blk_d = (frame_de && !rise) ? blk : 1'b0;
    assign qual       = blk & prev_blk_q & (x_q != '0);
    assign lo_x       = x_q - X_W'(1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_blk_q <= 1'b0;
        else        prev_blk_q <= prev_blk_d;
    end
`else
    assign qual = blk;
    assign lo_x = x_q;
`endif

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        min_x_d = min_x_q;
        max_x_d = max_x_q;
        min_y_d = min_y_q;
        max_y_d = max_y_q;
        trans_d = trans_q;
        hit_d   = hit_q;

        if (rise || !frame_de)  x_d = '0;
        else if (x_q != '1)     x_d = x_q + X_W'(1);

        if (rise)                                       y_d = '0;
        else if (de_q && !frame_de && (y_q != '1))      y_d = y_q + Y_W'(1);

        if (rise) begin
            min_x_d = '0;
            max_x_d = '0;
            min_y_d = '0;
            max_y_d = '0;
            trans_d = '0;
            hit_d   = 1'b0;
        end else if (accum_en) begin
            if (qual) begin
                hit_d = 1'b1;
                if (!hit_q) begin
                    min_x_d = lo_x;
                    max_x_d = x_q;
                    min_y_d = y_q;
                    max_y_d = y_q;
                end else begin
                    if (lo_x < min_x_q) min_x_d = lo_x;
                    if (x_q > max_x_q)  max_x_d = x_q;
                    if (y_q < min_y_q)  min_y_d = y_q;
                    if (y_q > max_y_q)  max_y_d = y_q;
                end
            end
            if (frame_de && monoc_fall && (trans_q != '1)) trans_d = trans_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_SYNC;
            vs_q        <= 1'b0;
            de_q        <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            min_x_q     <= '0;
            max_x_q     <= '0;
            min_y_q     <= '0;
            max_y_q     <= '0;
            trans_q     <= '0;
            hit_q       <= 1'b0;
            x_min_q     <= '0;
            x_max_q     <= '0;
            y_min_q     <= '0;
            y_max_q     <= '0;
            trans_cnt_q <= '0;
            found_q     <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            vs_q    <= frame_vsync;
            de_q    <= frame_de;
            x_q     <= x_d;
            y_q     <= y_d;
            min_x_q <= min_x_d;
            max_x_q <= max_x_d;
            min_y_q <= min_y_d;
            max_y_q <= max_y_d;
            trans_q <= trans_d;
            hit_q   <= hit_d;
            valid_q <= 1'b0;
            case (state_q)
                WAIT_SYNC: if (rise) state_q <= SCAN;
                SCAN: begin
                    if (rise) begin
                        x_min_q     <= hit_q ? min_x_q : '0;
                        x_max_q     <= hit_q ? max_x_q : '0;
                        y_min_q     <= hit_q ? min_y_q : '0;
                        y_max_q     <= hit_q ? max_y_q : '0;
                        trans_cnt_q <= trans_q;
                        found_q     <= hit_q;
                        valid_q     <= 1'b1;
                        state_q     <= REPORT;
                    end
                end
                REPORT:  state_q <= SCAN;
                default: state_q <= WAIT_SYNC;
            endcase
        end
    end

    assign x_min       = x_min_q;
    assign x_max       = x_max_q;
    assign y_min       = y_min_q;
    assign y_max       = y_max_q;
    assign trans_cnt   = trans_cnt_q;
    assign bbox_found  = found_q;
    assign bbox_valid  = valid_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_digit_bbox_detect.sv
// Bench for digit_bbox_detect: directed frame table, hand-written corner sequences and random frames vs a pixel-list model.
// A second instance with a 4-bit counter checks transition-count saturation on the same stimulus.
module tb_digit_bbox_detect;

  logic clk = 1'b0;
  logic rst_n;
  logic frame_vsync, frame_hsync, frame_de, monoc, monoc_fall;
  logic [10:0] x_min, x_max;
  logic [9:0]  y_min, y_max;
  logic [15:0] trans_cnt;
  logic        bbox_found, bbox_valid;
  logic [1:0]  dbg_state;
  logic [10:0] s_x_min, s_x_max;
  logic [9:0]  s_y_min, s_y_max;
  logic [3:0]  s_trans_cnt;
  logic        s_found, s_valid;
  logic [1:0]  s_state;

  digit_bbox_detect dut (
    .clk(clk), .rst_n(rst_n), .frame_vsync(frame_vsync), .frame_hsync(frame_hsync),
    .frame_de(frame_de), .monoc(monoc), .monoc_fall(monoc_fall),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
    .trans_cnt(trans_cnt), .bbox_found(bbox_found), .bbox_valid(bbox_valid),
    .dbg_state_o(dbg_state)
  );

  digit_bbox_detect #(.CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .frame_vsync(frame_vsync), .frame_hsync(frame_hsync),
    .frame_de(frame_de), .monoc(monoc), .monoc_fall(monoc_fall),
    .x_min(s_x_min), .x_max(s_x_max), .y_min(s_y_min), .y_max(s_y_max),
    .trans_cnt(s_trans_cnt), .bbox_found(s_found), .bbox_valid(s_valid),
    .dbg_state_o(s_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [10:0] xmin;
    logic [10:0] xmax;
    logic [9:0]  ymin;
    logic [9:0]  ymax;
    logic        found;
    logic [15:0] trans;
  } exp_t;

  typedef struct {
    int kind;  // 0 rectangle (rx0 < 0: all white), 1 two corner pixels, 2 alternating row
    int rx0, rx1, ry0, ry1;
    int exmin, exmax, eymin, eymax, efound, etrans;
  } vec_t;

  exp_t exp_q[$];
  bit   pix_q[$];   // 1 = black, row-major over all lines of the frame
  int   len_q[$];   // active pixels per line
  int   n_checks = 0;
  int   n_err = 0;
  int   exp_pulses = 0;
  int   seen_pulses = 0;

  always @(negedge clk) if (bbox_valid) seen_pulses++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: bounding box and fall count straight from the frame's pixel list.
  function automatic exp_t model_frame();
    exp_t e;
    int   base, xmn, xmx, ymn, ymx, tr, lo;
    bit   hit, prev, blk, qual;
    e = '0; base = 0; hit = 0; tr = 0;
    xmn = 0; xmx = 0; ymn = 0; ymx = 0;
    for (int ly = 0; ly < len_q.size(); ly++) begin
      prev = 0;
      for (int lx = 0; lx < len_q[ly]; lx++) begin
        blk = pix_q[base + lx];
        if (blk && lx > 0 && !prev) tr++;
`ifdef BBOX_NOISE_FILTER_EN
        qual = blk && prev;
        lo   = lx - 1;
`else
        qual = blk;
        lo   = lx;
`endif
        if (qual) begin
          if (!hit) begin
            xmn = lo; xmx = lx; ymn = ly; ymx = ly; hit = 1;
          end else begin
            if (lo < xmn) xmn = lo;
            if (lx > xmx) xmx = lx;
            if (ly < ymn) ymn = ly;
            if (ly > ymx) ymx = ly;
          end
        end
        prev = blk;
      end
      base += len_q[ly];
    end
    e.xmin = 11'(xmn); e.xmax = 11'(xmx); e.ymin = 10'(ymn); e.ymax = 10'(ymx);
    e.found = hit; e.trans = 16'(tr);
    return e;
  endfunction

  function automatic void build_table_frame(input vec_t v);
    pix_q.delete(); len_q.delete();
    if (v.kind == 2) begin
      len_q.push_back(64);
      for (int x = 0; x < 64; x++) pix_q.push_back(x[0]);
    end else begin
      for (int y = 0; y < 480; y++) begin
        if (v.kind == 1) begin
          if (y == 479) begin
            len_q.push_back(640);
            for (int x = 0; x < 640; x++) pix_q.push_back(x == 639);
          end else begin
            len_q.push_back(1);
            pix_q.push_back(y == 0);
          end
        end else if (v.rx0 >= 0 && y >= v.ry0 && y <= v.ry1) begin
          len_q.push_back(640);
          for (int x = 0; x < 640; x++) pix_q.push_back(x >= v.rx0 && x <= v.rx1);
        end else begin
          len_q.push_back(1);
          pix_q.push_back(1'b0);
        end
      end
    end
  endfunction

  function automatic void build_random_frame(input int n_lines, input bit all_white);
    int w;
    pix_q.delete(); len_q.delete();
    for (int y = 0; y < n_lines; y++) begin
      w = $urandom_range(1, 24);
      len_q.push_back(w);
      for (int x = 0; x < w; x++) pix_q.push_back(!all_white && ($urandom_range(0, 2) == 0));
    end
  endfunction

  function automatic void build_white_frame();
    pix_q.delete(); len_q.delete();
    for (int y = 0; y < 3; y++) begin
      len_q.push_back(8);
      for (int x = 0; x < 8; x++) pix_q.push_back(1'b0);
    end
  endfunction

  // driver: lines of the current frame, two blank cycles after each; optional reset at a line start
  task automatic send_frame(input int rst_line);
    int  base;
    bit  prev, blk;
    base = 0;
    for (int ly = 0; ly < len_q.size(); ly++) begin
      if (ly == rst_line) begin
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_x_min", 32'(x_min), 0);
        check("rst_x_max", 32'(x_max), 0);
        check("rst_y_min", 32'(y_min), 0);
        check("rst_y_max", 32'(y_max), 0);
        check("rst_trans", 32'(trans_cnt), 0);
        check("rst_found", 32'(bbox_found), 0);
        check("rst_state", 32'(dbg_state), 0);
        @(negedge clk);
        rst_n = 1'b1;
      end
      prev = 0;
      for (int lx = 0; lx < len_q[ly]; lx++) begin
        blk = pix_q[base + lx];
        @(negedge clk);
        frame_de   = 1'b1;
        monoc      = !blk;
        monoc_fall = blk && lx > 0 && !prev;
        prev = blk;
      end
      base += len_q[ly];
      @(negedge clk);
      frame_de = 1'b0; monoc = 1'b1; monoc_fall = 1'b0; frame_hsync = 1'b1;
      @(negedge clk);
      frame_hsync = 1'b0;
    end
  endtask

  // vsync rise; when a report is due, compare it against the scoreboard head in cycle N+1
  task automatic frame_boundary(input bit expect_report, input bit black_at_rise);
    exp_t e;
    @(negedge clk);
    frame_vsync = 1'b1;
    frame_de    = black_at_rise;
    monoc       = !black_at_rise;
    monoc_fall  = black_at_rise;
    @(negedge clk);
    frame_de = 1'b0; monoc = 1'b1; monoc_fall = 1'b0;
    check("valid_n1", 32'(bbox_valid), 32'(expect_report));
    check("state_n1", 32'(dbg_state), expect_report ? 2 : 1);
    if (expect_report) begin
      exp_pulses++;
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("x_min", 32'(x_min), 32'(e.xmin));
        check("x_max", 32'(x_max), 32'(e.xmax));
        check("y_min", 32'(y_min), 32'(e.ymin));
        check("y_max", 32'(y_max), 32'(e.ymax));
        check("found", 32'(bbox_found), 32'(e.found));
        check("trans", 32'(trans_cnt), 32'(e.trans));
        check("sat_trans", 32'(s_trans_cnt), (e.trans > 15) ? 15 : 32'(e.trans));
        check("sat_valid", 32'(s_valid), 1);
      end
    end
    @(negedge clk);
    check("valid_n2", 32'(bbox_valid), 0);
    frame_vsync = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_vec(input vec_t v);
    exp_t e;
    e.xmin = 11'(v.exmin); e.xmax = 11'(v.exmax);
    e.ymin = 10'(v.eymin); e.ymax = 10'(v.eymax);
    e.found = v.efound[0]; e.trans = 16'(v.etrans);
    exp_q.push_back(e);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{0, 100, 149, 50, 79, 100, 149, 50, 79, 1, 30};
    vecs[1] = '{0, -1, -1, -1, -1, 0, 0, 0, 0, 0, 0};
    vecs[3] = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0};
`ifdef BBOX_NOISE_FILTER_EN
    vecs[2] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[4] = '{2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32};
`else
    vecs[2] = '{1, 0, 0, 0, 0, 0, 639, 0, 479, 1, 1};
    vecs[4] = '{2, 0, 0, 0, 0, 1, 63, 0, 0, 1, 32};
`endif

    rst_n = 1'b0;
    frame_vsync = 1'b0; frame_hsync = 1'b0; frame_de = 1'b0; monoc = 1'b1; monoc_fall = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_x_min", 32'(x_min), 0);
    check("reset_x_max", 32'(x_max), 0);
    check("reset_y_min", 32'(y_min), 0);
    check("reset_y_max", 32'(y_max), 0);
    check("reset_trans", 32'(trans_cnt), 0);
    check("reset_found", 32'(bbox_found), 0);
    check("reset_valid", 32'(bbox_valid), 0);
    check("reset_state", 32'(dbg_state), 0);
    rst_n = 1'b1;

    // startup: partial frame with black pixels is discarded, first rise gives no report
    build_random_frame(4, 1'b0);
    send_frame(-1);
    frame_boundary(1'b0, 1'b0);

    // directed frame table
    for (int i = 0; i < 5; i++) begin
      build_table_frame(vecs[i]);
      push_vec(vecs[i]);
      send_frame(-1);
      frame_boundary(1'b1, 1'b0);
    end

    // black pixel and fall flag in the vsync-rise cycle belong to neither frame
    build_white_frame();
    exp_q.push_back(model_frame());
    send_frame(-1);
    frame_boundary(1'b1, 1'b1);
    build_white_frame();
    exp_q.push_back(model_frame());
    send_frame(-1);
    frame_boundary(1'b1, 1'b0);

    // random frames against the model
    for (int f = 0; f < 16; f++) begin
      build_random_frame($urandom_range(1, 12), $urandom_range(0, 5) == 0);
      exp_q.push_back(model_frame());
      send_frame(-1);
      frame_boundary(1'b1, 1'b0);
    end

    // mid-frame reset: partial frame discarded, next rise silent, following frame reports
    build_random_frame(8, 1'b0);
    send_frame(4);
    frame_boundary(1'b0, 1'b0);
    build_random_frame(6, 1'b0);
    exp_q.push_back(model_frame());
    send_frame(-1);
    frame_boundary(1'b1, 1'b0);

    repeat (3) @(negedge clk);
    check("valid_pulses", 32'(seen_pulses), 32'(exp_pulses));
    check("scoreboard_left", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
